// File: rtl/nlprg3_checker.sv
// Receive-side checker for the 3-bit nonlinear PRG word stream.
// It self-synchronises, locks, then flywheels its own model and counts word errors.
module nlprg3_checker #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, PRIME, HUNT, LOCKED} state_t;

  localparam logic [3:0] LOCK_LIM = LOCK_CNT[3:0];
  localparam logic [3:0] LOSS_LIM = LOSS_CNT[3:0];

  state_t           state_reg, state_next;
  logic [2:0]       p_reg, p_next;
  logic [2:0]       c_reg, c_next;
  logic [3:0]       match_reg, match_next;
  logic [3:0]       loss_reg, loss_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pulse_reg, pulse_next;
  logic             lost_reg, lost_next;

  logic       well_formed;
  logic       n1;
  logic [2:0] pred;
  logic       hit;
  logic [3:0] match_inc;
  logic [3:0] loss_inc;

  // In LOCKED, p_reg/c_reg act as the free-running generator model.
  assign well_formed = (in_data[0] == in_data[1]);
  assign n1          = (c_reg[0] ^ ~p_reg[2]) ^ (c_reg[2] | c_reg[0]);
  assign pred        = {c_reg[0], n1, n1};
  assign hit         = well_formed && (in_data == pred);
  assign match_inc   = match_reg + 4'd1;
  assign loss_inc    = loss_reg + 4'd1;

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    c_next     = c_reg;
    match_next = match_reg;
    loss_next  = loss_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    lost_next  = 1'b0;
    if (in_valid) begin
      unique case (state_reg)
        IDLE: begin
          if (well_formed) begin
            p_next     = in_data;
            state_next = PRIME;
          end
        end
        PRIME: begin
          if (well_formed) begin
            c_next     = in_data;
            match_next = 4'd0;
            state_next = HUNT;
          end else begin
            state_next = IDLE;
          end
        end
        HUNT: begin
          if (hit) begin
            p_next     = c_reg;
            c_next     = in_data;
            match_next = match_inc;
            if (match_inc == LOCK_LIM) begin
              state_next = LOCKED;
              loss_next  = 4'd0;
            end
          end else if (well_formed) begin
            p_next     = in_data;
            state_next = PRIME;
          end else begin
            state_next = IDLE;
          end
        end
        LOCKED: begin
          p_next = c_reg;
          c_next = pred;
          if (hit) begin
            loss_next = 4'd0;
          end else begin
            pulse_next = 1'b1;
            loss_next  = loss_inc;
            if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + 1'b1;
            if (loss_inc == LOSS_LIM) begin
              lost_next  = 1'b1;
              state_next = IDLE;
              p_next     = 3'd0;
              c_next     = 3'd0;
              match_next = 4'd0;
              loss_next  = 4'd0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
    // A clear on the same edge as an error takes priority.
    if (clear_cnt) cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      p_reg     <= 3'd0;
      c_reg     <= 3'd0;
      match_reg <= 4'd0;
      loss_reg  <= 4'd0;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      c_reg     <= c_next;
      match_reg <= match_next;
      loss_reg  <= loss_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
      lost_reg  <= lost_next;
    end
  end

  assign locked    = (state_reg == LOCKED);
  assign err_pulse = pulse_reg;
  assign lock_lost = lost_reg;
  assign err_cnt   = cnt_reg;

endmodule
